// File: rtl/pcie_us_rq_tag_mgr_pkg.sv
// ============================================================================
// Module   : pcie_us_tag_pkg
// Brief    : Shared tag widths, non-extended tag limit and tag type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pcie_us_tag_pkg;

    localparam int TAG_WIDTH_8       = 8;
    localparam int TAG_WIDTH_10      = 10;
    localparam int NON_EXT_TAG_LIMIT = 32;

    // Sized for the widest tag field; narrower configurations zero-extend.
    typedef logic [TAG_WIDTH_10-1:0] tag_t;

endpackage

`default_nettype wire

// File: rtl/pcie_us_rq_tag_mgr_if.sv
// ============================================================================
// Module   : pcie_us_rq_tag_mgr_if
// Brief    : Tag offer stream and tag release strobe between DMA and manager.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pcie_us_rq_tag_mgr_if #(
    parameter int TAG_WIDTH = 8
);
    logic [TAG_WIDTH-1:0] m_axis_tag_tdata;
    logic                 m_axis_tag_tvalid;
    logic                 m_axis_tag_tready;
    logic [TAG_WIDTH-1:0] s_axis_release_tdata;
    logic                 s_axis_release_tvalid;

    modport master (
        output m_axis_tag_tdata,
        output m_axis_tag_tvalid,
        input  m_axis_tag_tready,
        input  s_axis_release_tdata,
        input  s_axis_release_tvalid
    );

    modport slave (
        input  m_axis_tag_tdata,
        input  m_axis_tag_tvalid,
        output m_axis_tag_tready,
        output s_axis_release_tdata,
        output s_axis_release_tvalid
    );
endinterface

`default_nettype wire

// File: rtl/pcie_us_rq_tag_mgr_prio_enc.sv
// ============================================================================
// Module   : pcie_us_tag_prio_enc
// Brief    : Combinational lowest-set-bit priority encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pcie_us_tag_prio_enc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scanning downwards leaves the lowest set bit as the final assignment.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcie_us_rq_tag_mgr.sv
// ============================================================================
// Module   : pcie_us_rq_tag_mgr
// Brief    : Lowest-free requester tag allocator with release checking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pcie_us_rq_tag_mgr
    import pcie_us_tag_pkg::*;
#(
    parameter int TAG_WIDTH = TAG_WIDTH_8,
    parameter int TAG_COUNT = 256,
    parameter int CNT_WIDTH = $clog2(TAG_COUNT + 1)
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    input  logic                    ext_tag_en,
    pcie_us_rq_tag_mgr_if.master    tag_if,
    output logic                    release_error,
    output logic [CNT_WIDTH-1:0]    outstanding_count,
    output logic                    tags_empty,
    output logic                    tags_exhausted
);

    localparam int IDX_W = $clog2(TAG_COUNT);

    logic [TAG_COUNT-1:0] r_free;
    logic                 r_offer_valid;
    logic [IDX_W-1:0]     r_offer_idx;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_release_error;
    logic                 r_empty;
    logic                 r_exhausted;

    logic [TAG_COUNT-1:0] w_range_mask;
    logic [TAG_COUNT-1:0] w_avail;
    logic [TAG_COUNT-1:0] w_free_next;
    logic                 w_offer_valid_next;
    logic [IDX_W-1:0]     w_offer_idx_next;
    logic [CNT_WIDTH-1:0] w_count_next;
    logic                 w_cand_valid;
    logic [IDX_W-1:0]     w_cand_idx;
    logic [TAG_WIDTH-1:0] w_rel_tag;
    logic [IDX_W-1:0]     w_rel_idx;
    logic                 w_rel_in_range;
    logic                 w_rel_legal;
    logic                 w_hs;
    logic                 w_flush;
    logic                 w_load;

    generate
        for (genvar i = 0; i < TAG_COUNT; i++) begin : g_mask
            assign w_range_mask[i] = (i < NON_EXT_TAG_LIMIT) ? 1'b1 : ext_tag_en;
        end
    endgenerate

    assign w_avail = r_free & w_range_mask;

    pcie_us_tag_prio_enc #(
        .WIDTH (TAG_COUNT),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (w_avail),
        .valid (w_cand_valid),
        .index (w_cand_idx)
    );

    assign w_hs           = r_offer_valid && tag_if.m_axis_tag_tready;
    assign w_rel_tag      = tag_if.s_axis_release_tdata;
    assign w_rel_in_range = 32'(w_rel_tag) < 32'(TAG_COUNT);
    assign w_rel_idx      = w_rel_tag[IDX_W-1:0];

    // The offered tag already reads as allocated in the bitmap, so it needs its own exclusion.
    assign w_rel_legal = tag_if.s_axis_release_tvalid && w_rel_in_range &&
                         !r_free[w_rel_idx] &&
                         !(r_offer_valid && (w_rel_idx == r_offer_idx));

    assign w_flush = r_offer_valid && !ext_tag_en && !w_hs &&
                     (32'(r_offer_idx) >= NON_EXT_TAG_LIMIT);
    assign w_load  = !w_flush && (!r_offer_valid || w_hs) && w_cand_valid;

    always_comb begin
        w_free_next        = r_free;
        w_offer_valid_next = r_offer_valid;
        w_offer_idx_next   = r_offer_idx;
        if (w_rel_legal) begin
            w_free_next[w_rel_idx] = 1'b1;
        end
        if (w_flush) begin
            w_free_next[r_offer_idx] = 1'b1;
            w_offer_valid_next       = 1'b0;
        end else if (w_load) begin
            w_free_next[w_cand_idx] = 1'b0;
            w_offer_valid_next      = 1'b1;
            w_offer_idx_next        = w_cand_idx;
        end else if (w_hs) begin
            w_offer_valid_next = 1'b0;
        end
    end

    assign w_count_next = r_count + CNT_WIDTH'(w_hs) - CNT_WIDTH'(w_rel_legal);

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            r_free          <= '1;
            r_offer_valid   <= 1'b0;
            r_offer_idx     <= '0;
            r_count         <= '0;
            r_release_error <= 1'b0;
            r_empty         <= 1'b1;
            r_exhausted     <= 1'b0;
        end else begin
            r_free          <= w_free_next;
            r_offer_valid   <= w_offer_valid_next;
            r_offer_idx     <= w_offer_idx_next;
            r_count         <= w_count_next;
            r_release_error <= tag_if.s_axis_release_tvalid && !w_rel_legal;
            r_empty         <= (w_count_next == '0);
            r_exhausted     <= !w_offer_valid_next && !(|(w_free_next & w_range_mask));
        end
    end

    assign tag_if.m_axis_tag_tdata  = TAG_WIDTH'(r_offer_idx);
    assign tag_if.m_axis_tag_tvalid = r_offer_valid;
    assign release_error            = r_release_error;
    assign outstanding_count        = r_count;
    assign tags_empty               = r_empty;
    assign tags_exhausted           = r_exhausted;

endmodule

`default_nettype wire
